// File: rtl/axis_pkg.sv
// Shared AXI-Stream types and default widths for the axis_m / axis_s_rx pair.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;
    localparam int AXIS_DEPTH  = 8;
    localparam int AXIS_CNT_W  = 8;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } axis_beat_t;

    typedef enum logic {
        RX_IDLE,
        RX_IN_PKT
    } rx_state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding {data, last} beats.
module axis_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_last,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dlast,
    output logic                     dvalid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [DATA_W:0]  head;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (level_q == LW'(DEPTH));
    assign dvalid  = (level_q != '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && dvalid;
    assign level   = level_q;

    assign head  = mem_q[rd_ptr_q];
    assign dout  = head[DATA_W:1];
    assign dlast = head[0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_fire && !rd_fire) level_d = level_q + LW'(1);
        else if (rd_fire && !wr_fire) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because dvalid gates them.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= {wr_data, wr_last};
    end

endmodule

// File: rtl/axis_s_rx.sv
// AXI-Stream slave receiver: FWFT beat buffer plus packet framing counters.
//   state     | meaning
//   RX_IDLE   | between packets, next accepted beat starts a packet
//   RX_IN_PKT | at least one non-last beat of the current packet accepted
module axis_s_rx
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int DEPTH  = AXIS_DEPTH,
    parameter int CNT_W  = AXIS_CNT_W
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dlast,
    output logic                     dvalid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     pkt_active,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         last_len
);
    logic             full;
    logic             accept;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cur_len_q, cur_len_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] last_len_q, last_len_d;
    logic [CNT_W-1:0] len_inc;

    // Ready depends only on registered occupancy so a full FIFO freed by a pop reopens one cycle later.
    assign s_axis_tready = s_axis_aresetn && !full;
    assign accept        = s_axis_tvalid && s_axis_tready;

    axis_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_aresetn),
        .wr_en   (accept),
        .wr_data (s_axis_tdata),
        .wr_last (s_axis_tlast),
        .rd_en   (rd_en),
        .dout    (dout),
        .dlast   (dlast),
        .dvalid  (dvalid),
        .full    (full),
        .level   (level)
    );

    assign len_inc = (cur_len_q == '1) ? cur_len_q : cur_len_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_len_d  = cur_len_q;
        pkt_cnt_d  = pkt_cnt_q;
        last_len_d = last_len_q;
        if (accept) begin
            if (s_axis_tlast) begin
                state_d    = RX_IDLE;
                pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
                last_len_d = len_inc;
                cur_len_d  = '0;
            end else begin
                state_d   = RX_IN_PKT;
                cur_len_d = len_inc;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q    <= RX_IDLE;
            cur_len_q  <= '0;
            pkt_cnt_q  <= '0;
            last_len_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_len_q  <= cur_len_d;
            pkt_cnt_q  <= pkt_cnt_d;
            last_len_q <= last_len_d;
        end
    end

    assign pkt_active = (state_q == RX_IN_PKT);
    assign pkt_cnt    = pkt_cnt_q;
    assign last_len   = last_len_q;

endmodule

// File: tb/tb_axis_s_rx.sv
// Randomized and directed bench for axis_s_rx against a queue-based reference model.
module tb_axis_s_rx;
    import axis_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       dlast;
    logic       dvalid;
    logic [3:0] level;
    logic       pkt_active;
    logic [7:0] pkt_cnt;
    logic [7:0] last_len;

    always #5 clk = ~clk;

    axis_s_rx #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .rd_en          (rd_en),
        .dout           (dout),
        .dlast          (dlast),
        .dvalid         (dvalid),
        .level          (level),
        .pkt_active     (pkt_active),
        .pkt_cnt        (pkt_cnt),
        .last_len       (last_len)
    );

    axis_beat_t mq[$];
    int m_len, m_cnt, m_last;
    bit m_in;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_len = 0; m_cnt = 0; m_last = 0; m_in = 0;
    endtask

    // One clock: drive, check outputs against the model mid-cycle, then advance the model.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit r, output bit acc);
        bit pop;
        axis_beat_t b;
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; rd_en = r;
        @(negedge clk);
        chk_eq("tready", 32'(s_axis_tready), 32'(mq.size() < DEPTH));
        chk_eq("level", 32'(level), 32'(mq.size()));
        chk_eq("dvalid", 32'(dvalid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk_eq("dout", 32'(dout), 32'(mq[0].data));
            chk_eq("dlast", 32'(dlast), 32'(mq[0].last));
        end
        chk_eq("pkt_active", 32'(pkt_active), 32'(m_in));
        chk_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
        chk_eq("last_len", 32'(last_len), 32'(m_last));
        acc = v && (mq.size() < DEPTH);
        pop = r && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            b.data = d; b.last = l;
            mq.push_back(b);
            if (l) begin
                m_last = (m_len + 1 > 255) ? 255 : m_len + 1;
                m_cnt  = (m_cnt + 1) % 256;
                m_len  = 0;
                m_in   = 0;
            end else begin
                m_len = (m_len < 255) ? m_len + 1 : 255;
                m_in  = 1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; s_axis_tvalid = 1'b1; rd_en = 1'b0;
        #1;
        chk_eq("rst_tready", 32'(s_axis_tready), 32'd0);
        chk_eq("rst_level", 32'(level), 32'd0);
        chk_eq("rst_dvalid", 32'(dvalid), 32'd0);
        chk_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk_eq("rst_last_len", 32'(last_len), 32'd0);
        chk_eq("rst_pkt_active", 32'(pkt_active), 32'd0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_tready_hold", 32'(s_axis_tready), 32'd0);
        s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bit a;
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
    endtask

    initial begin
        bit acc;
        int idx, nacc, cyc;
        logic [7:0] t1 [4];
        axis_beat_t stream[$];
        axis_beat_t b;

        model_reset();
        #2;
        do_reset(10);

        // 1: four-beat packet with continuous popping
        t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;
        for (int i = 0; i < 4; i++) cycle(1'b1, t1[i], i == 3, 1'b1, acc);
        chk_eq("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk_eq("t1_last_len", 32'(last_len), 32'd4);
        drain(2);

        // 2: fill without popping, then a single pop reopens ready one cycle later
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'hA0 + 8'(idx), idx == 9, 1'b0, acc);
            if (acc) idx++;
        end
        chk_eq("t2_level_full", 32'(level), 32'd8);
        chk_eq("t2_accepted", 32'(idx), 32'd8);
        cycle(1'b1, 8'hA0 + 8'(idx), idx == 9, 1'b1, acc);
        chk_eq("t2_no_acc_on_pop", 32'(acc), 32'd0);
        cycle(1'b1, 8'hA0 + 8'(idx), idx == 9, 1'b0, acc);
        chk_eq("t2_ninth_acc", 32'(acc), 32'd1);

        // 3: full FIFO with simultaneous push/pop settles to one beat per cycle
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1, acc);
            if (acc) nacc++;
        end
        chk_eq("t3_rate", 32'(nacc), 32'd11);
        cycle(1'b1, 8'hCF, 1'b1, 1'b1, acc);
        drain(10);

        // 4: back-to-back single-beat packets
        do_reset(3);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1, 1'b1, acc);
        chk_eq("t4_pkt_cnt", 32'(pkt_cnt), 32'd5);
        chk_eq("t4_last_len", 32'(last_len), 32'd1);
        drain(2);

        // 5: reset in the middle of a packet
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, acc);
        chk_eq("t5_active", 32'(pkt_active), 32'd1);
        do_reset(4);
        cycle(1'b1, 8'h81, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'h82, 1'b1, 1'b1, acc);
        chk_eq("t5_last_len", 32'(last_len), 32'd2);
        chk_eq("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);
        drain(3);

        // cur_len saturation on a long packet
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i), i == 299, 1'b1, acc);
        chk_eq("sat_last_len", 32'(last_len), 32'd255);
        drain(3);

        // 6: five random packets with random valid and pop pressure
        do_reset(2);
        for (int p = 0; p < 5; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                b.data = 8'($urandom);
                b.last = (k == len - 1);
                stream.push_back(b);
            end
        end
        cyc = 0;
        while ((stream.size() > 0 || mq.size() > 0) && cyc < 2000) begin
            if (stream.size() > 0)
                cycle($urandom_range(0, 9) < 7, stream[0].data, stream[0].last, $urandom_range(0, 9) < 6, acc);
            else
                cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
            if (acc) void'(stream.pop_front());
            cyc++;
        end
        chk_eq("t6_done_in_budget", 32'(cyc < 2000), 32'd1);
        chk_eq("t6_pkt_cnt", 32'(pkt_cnt), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
